mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: the maximum number of wait cycles before a timeout; only used when the timeout is compiled in.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port if_req, input, 1: instruction-fetch request, level, held until if_valid.
REQ-005 SHALL have port if_addr, input, 32: fetch word address.
REQ-006 SHALL have port if_rdata, output, 32: fetched word; if_valid, output, 1: one-cycle completion pulse.
REQ-007 SHALL have port d_req, input, 1: data request, level, held until d_valid or d_err.
REQ-008 SHALL have ports d_we (input, 1: store when 1), d_size (input, 3: 000 B, 001 H, 010 W, 100 BU, 101 HU), d_addr (input, 32), d_wdata (input, 32).
REQ-009 SHALL have port d_rdata, output, 32: raw aligned memory word; byte/half extraction is downstream.
REQ-010 SHALL have port d_valid, output, 1: one-cycle completion pulse; d_err, output, 1: one-cycle misalign/timeout pulse.
REQ-011 SHALL have ports mem_addr (output, 32, {addr[31:2],2'b00}), mem_wdata (output, 32), mem_we (output, 4: byte write enables), mem_re (output, 1), mem_ready (input, 1), mem_rdata (input, 32).

Function
REQ-012 SHALL use FSM states IDLE, IF_ACC, D_ACC.
- IDLE: grant and leave on a request.
- IF_ACC / D_ACC: hold the access until mem_ready, then return to IDLE.
REQ-013 SHALL arbitrate in IDLE when both requests are pending:
- Grant the requester not served last (last_grant flag).
- A single pending request is granted immediately.
REQ-014 SHALL register the memory outputs, so mem_re/mem_we assert in the cycle after the grant.
REQ-015 SHALL hold mem_addr, mem_wdata, mem_we and mem_re constant until the cycle mem_ready is sampled high.
REQ-016 SHALL, in the mem_ready cycle:
- Capture mem_rdata into if_rdata or d_rdata.
- Pulse if_valid or d_valid the next cycle.
- Deassert mem_re/mem_we.
- Return to IDLE.
Minimum latency is 3 cycles from request to valid, with mem_ready tied high.
REQ-017 SHALL generate the store byte enables as follows:
- Byte (000/100): mem_we = 4'b0001 << addr[1:0], byte replicated 4x on mem_wdata.
- Half (001/101): mem_we = 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1, half replicated 2x.
- Word (010): mem_we = 4'b1111.
REQ-018 SHALL, for a load, drive mem_we = 0 and mem_re = 1; for a store, drive mem_re = 0.
REQ-019 SHALL treat the following as misaligned: half with addr[0]=1, word with addr[1:0]!=0, or any d_size value not listed in REQ-008.
- No memory access is issued.
- d_err pulses one cycle after the grant.
- The FSM stays in IDLE, and last_grant updates to data.
REQ-020 SHALL give if_rdata and d_rdata each their own capture register, holding the value until the next completion on that port.
REQ-021 SHALL not let a request rising during an access preempt it; the request is evaluated in the next IDLE cycle.
REQ-022 SHALL never assert if_valid and d_valid in the same cycle.

Reset
REQ-023 SHALL, while rst_n=0, immediately drive:
- State: IDLE; last_grant: IF, so data wins the first tie.
- Outputs: all valid/err 0, mem_re 0, mem_we 0, mem_addr 0, mem_wdata 0, if_rdata 0, d_rdata 0.
- Timeout counter: 0.
REQ-024 SHALL, on reset mid-access:
- Abandon the access with no valid or err pulse.
- Resume arbitration on the first clk edge after rst_n rises.

Configuration
REQ-025 SHALL, when MEM_ARB_TIMEOUT_EN is defined:
- Count wait cycles in IF_ACC/D_ACC.
- If mem_ready is still low after WAIT_MAX cycles, deassert the memory strobes and return to IDLE.
- For a data access, pulse d_err.
- For a fetch, pulse if_valid with if_rdata = 32'h0000_0000.
REQ-026 SHALL, when MEM_ARB_TIMEOUT_EN is undefined, have no counter and wait indefinitely for mem_ready.

Verification
REQ-027 SHALL cover a byte store: d_req, d_we=1, d_size=000, d_addr=0x1000_0003, d_wdata=0xAB, mem_ready=1 -> mem_we=1000, mem_wdata=0xABABABAB, d_valid pulse in cycle 3.
REQ-028 SHALL cover a tie after reset: if_req and d_req rise together, if_addr=0x0, d_addr=0x1000_0010, load -> data served first, then IF; if_rdata = mem_rdata of the second access.
REQ-029 SHALL cover misalignment: d_size=010, d_addr=0x1000_0002 -> no mem_re/mem_we, d_err pulse one cycle after the grant.
REQ-030 SHALL cover the wait state: mem_ready low for 4 cycles on a load at 0x1000_0008 -> mem_addr/mem_re stable throughout, d_valid one cycle after mem_ready, d_rdata = mem_rdata.
REQ-031 SHALL cover timeout (MEM_ARB_TIMEOUT_EN, WAIT_MAX=15): mem_ready held 0 -> d_err after 15 wait cycles, FSM back in IDLE, the next if_req is served.
REQ-032 SHALL cover reset mid-access: rst_n=0 in D_ACC -> mem_re=0 immediately, no d_valid, IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-ported memory bus.
// Optional wait-state timeout compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   output logic        mem_re,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'b00, IF_ACC = 2'b01, D_ACC = 2'b10} state_t;

   state_t      state;
   logic        last_grant;   // 1 = data port was served last
   logic        if_pend;
   logic        d_pend;
   logic        grant_d;
   logic        misalign;
   logic [3:0]  st_we;
   logic [31:0] st_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(WAIT_MAX + 1);
   logic [CW-1:0] wait_cnt;
`else
   localparam int unused_wait_max = WAIT_MAX;
`endif

   // A requester still holds its level during its completion pulse; mask it so it is not re-granted.
   always_comb begin
      if_pend  = if_req & ~if_valid;
      d_pend   = d_req & ~d_valid & ~d_err;
      grant_d  = d_pend & (~if_pend | ~last_grant);
      misalign = 1'b0;
      st_we    = 4'b0000;
      st_wdata = d_wdata;
      case (d_size)
         3'b000, 3'b100: begin
            st_we    = 4'b0001 << d_addr[1:0];
            st_wdata = {4{d_wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            misalign = d_addr[0];
            st_we    = d_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{d_wdata[15:0]}};
         end
         3'b010: begin
            misalign = (d_addr[1:0] != 2'b00);
            st_we    = 4'b1111;
         end
         default: begin
            misalign = 1'b1;
         end
      endcase
   end

   // Arbitration FSM with registered memory strobes and completion pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         d_err      <= 1'b0;
         if_rdata   <= 32'h0000_0000;
         d_rdata    <= 32'h0000_0000;
         mem_addr   <= 32'h0000_0000;
         mem_wdata  <= 32'h0000_0000;
         mem_we     <= 4'b0000;
         mem_re     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  last_grant <= 1'b1;
                  if (misalign) begin
                     d_err <= 1'b1;
                  end else begin
                     state    <= D_ACC;
                     mem_addr <= {d_addr[31:2], 2'b00};
                     if (d_we) begin
                        mem_we    <= st_we;
                        mem_wdata <= st_wdata;
                        mem_re    <= 1'b0;
                     end else begin
                        mem_we    <= 4'b0000;
                        mem_wdata <= 32'h0000_0000;
                        mem_re    <= 1'b1;
                     end
                  end
               end else if (if_pend) begin
                  last_grant <= 1'b0;
                  state      <= IF_ACC;
                  mem_addr   <= {if_addr[31:2], 2'b00};
                  mem_wdata  <= 32'h0000_0000;
                  mem_we     <= 4'b0000;
                  mem_re     <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            IF_ACC, D_ACC: begin
               if (mem_ready) begin
                  state  <= IDLE;
                  mem_we <= 4'b0000;
                  mem_re <= 1'b0;
                  if (state == IF_ACC) begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end else begin
                     d_rdata <= mem_rdata;
                     d_valid <= 1'b1;
                  end
`ifdef MEM_ARB_TIMEOUT_EN
                  wait_cnt <= '0;
               end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
                  state    <= IDLE;
                  mem_we   <= 4'b0000;
                  mem_re   <= 1'b0;
                  wait_cnt <= '0;
                  if (state == IF_ACC) begin
                     if_rdata <= 32'h0000_0000;
                     if_valid <= 1'b1;
                  end else begin
                     d_err <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
`else
               end else begin
                  state <= state;
`endif
               end
            end
            default: begin
               state  <= IDLE;
               mem_we <= 4'b0000;
               mem_re <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a negedge monitor pops them.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        d_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic        mem_re;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          kind;     // 0 if_valid, 1 d_valid, 2 d_err
      bit          chk_data;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   mem_arbiter #(.WAIT_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory returns address XOR DEADBEEF so every word is distinct.
   assign mem_rdata = mem_addr ^ 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input bit chk, input logic [31:0] data);
      exp_t e;
      e.kind = kind; e.chk_data = chk; e.data = data;
      sb.push_back(e);
   endtask

   // Monitor: every completion pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (if_valid || d_valid || d_err)) begin
         exp_t e;
         int   k;
         k = if_valid ? 0 : (d_valid ? 1 : 2);
         check("valid_exclusive", {31'd0, if_valid & d_valid}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", k, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", k, e.kind);
            if (e.chk_data) check("rdata", (k == 0) ? if_rdata : d_rdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Wait (bounded) until the given pulse is visible; returns cycles waited.
   task automatic wait_pulse(input int kind, input int bound, output int cyc);
      cyc = 0;
      for (int i = 1; i <= bound; i++) begin
         tick();
         if ((kind == 0 && if_valid) || (kind == 1 && d_valid) || (kind == 2 && d_err)) begin
            cyc = i;
            return;
         end
      end
      check("wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic d_drive(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
   endtask

   typedef struct {
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  we;
      logic [31:0] mwd;
   } st_vec_t;

   initial begin
      int          cyc;
      logic [31:0] a0;
      st_vec_t     stv[3];
      logic [2:0]  bad_sz[3];
      logic [31:0] bad_a[3];

      rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_size = 3'b010; d_addr = 32'h0; d_wdata = 32'h0; mem_ready = 1'b1;
      #12;
      check("rst_mem_re", {31'd0, mem_re}, 32'd0);
      check("rst_mem_we", {28'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_pulses", {29'd0, if_valid, d_valid, d_err}, 32'd0);
      check("rst_rdata", if_rdata | d_rdata, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Tie after reset: data first, then fetch.
      tick();
      if_req = 1'b1; if_addr = 32'h0;
      d_drive(1'b0, 3'b010, 32'h1000_0010, 32'h0);
      push(1, 1'b1, 32'hCEAD_BEFF);
      push(0, 1'b1, 32'hDEAD_BEEF);
      tick();
      check("tie_d_addr", mem_addr, 32'h1000_0010);
      check("tie_d_re", {31'd0, mem_re}, 32'd1);
      wait_pulse(1, 5, cyc);
      d_req = 1'b0;
      tick();
      check("tie_if_addr", mem_addr, 32'h0);
      check("tie_if_re", {31'd0, mem_re}, 32'd1);
      wait_pulse(0, 5, cyc);
      if_req = 1'b0;
      tick();

      // Byte store at offset 3, completion exactly in cycle 3.
      d_drive(1'b1, 3'b000, 32'h1000_0003, 32'h0000_00AB);
      push(1, 1'b0, 32'h0);
      tick();
      check("sb_mem_we", {28'd0, mem_we}, 32'h8);
      check("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
      check("sb_mem_re", {31'd0, mem_re}, 32'd0);
      tick();
      check("sb_d_valid_cycle3", {31'd0, d_valid}, 32'd1);
      d_req = 1'b0;
      tick();

      // Further store enables: half upper, half lower unsigned, word.
      stv[0] = '{3'b001, 32'h1000_0002, 32'h0000_1234, 4'b1100, 32'h1234_1234};
      stv[1] = '{3'b101, 32'h1000_0000, 32'hFFFF_5678, 4'b0011, 32'h5678_5678};
      stv[2] = '{3'b010, 32'h1000_0004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
      foreach (stv[i]) begin
         d_drive(1'b1, stv[i].sz, stv[i].a, stv[i].wd);
         push(1, 1'b0, 32'h0);
         tick();
         check("st_mem_we", {28'd0, mem_we}, {28'd0, stv[i].we});
         check("st_mem_wdata", mem_wdata, stv[i].mwd);
         wait_pulse(1, 5, cyc);
         d_req = 1'b0;
         tick();
      end

      // Misaligned / illegal sizes: no access, d_err one cycle after grant.
      bad_sz[0] = 3'b010; bad_a[0] = 32'h1000_0002;
      bad_sz[1] = 3'b001; bad_a[1] = 32'h1000_0001;
      bad_sz[2] = 3'b011; bad_a[2] = 32'h1000_0000;
      foreach (bad_sz[i]) begin
         d_drive(1'b0, bad_sz[i], bad_a[i], 32'h0);
         push(2, 1'b0, 32'h0);
         tick();
         check("mis_d_err", {31'd0, d_err}, 32'd1);
         check("mis_no_access", {27'd0, mem_re, mem_we}, 32'd0);
         d_req = 1'b0;
         tick();
         check("mis_no_access_after", {27'd0, mem_re, mem_we}, 32'd0);
      end

      // Wait states: four cycles of mem_ready low on a load.
      mem_ready = 1'b0;
      d_drive(1'b0, 3'b010, 32'h1000_0008, 32'h0);
      push(1, 1'b1, 32'hCEAD_BEE7);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ws_addr_stable", mem_addr, 32'h1000_0008);
         check("ws_re_stable", {31'd0, mem_re, d_valid}, 32'd2);
      end
      mem_ready = 1'b1;
      tick();
      check("ws_d_valid", {31'd0, d_valid}, 32'd1);
      check("ws_d_rdata", d_rdata, 32'hCEAD_BEE7);
      check("ws_re_off", {31'd0, mem_re}, 32'd0);
      d_req = 1'b0;
      tick();

      // Reset during a data access.
      mem_ready = 1'b0;
      d_drive(1'b0, 3'b010, 32'h1000_0004, 32'h0);
      tick();
      check("mid_re_before", {31'd0, mem_re}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_re_reset", {31'd0, mem_re}, 32'd0);
      check("mid_d_rdata_reset", d_rdata, 32'h0);
      d_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      mem_ready = 1'b1;
      tick(); tick();
      if_req = 1'b1; if_addr = 32'h0000_0020;
      push(0, 1'b1, 32'hDEAD_BECF);
      wait_pulse(0, 5, cyc);
      check("post_rst_latency", cyc, 32'd2);
      if_req = 1'b0;
      tick();

`ifdef MEM_ARB_TIMEOUT_EN
      // Timeout: data gets d_err, fetch afterwards is served normally.
      mem_ready = 1'b0;
      d_drive(1'b0, 3'b010, 32'h1000_000C, 32'h0);
      push(2, 1'b0, 32'h0);
      wait_pulse(2, 40, cyc);
      check("to_cycles", cyc, 32'd16);
      check("to_re_off", {31'd0, mem_re}, 32'd0);
      d_req = 1'b0;
      mem_ready = 1'b1;
      if_req = 1'b1; if_addr = 32'h0000_0040;
      push(0, 1'b1, 32'hDEAD_BEAF);
      wait_pulse(0, 6, cyc);
      if_req = 1'b0;
      tick();
`endif

      tick(); tick();
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
